// File: rtl/act_scheduler.sv
// Purpose : shares one segmentation lookup and one multiply-add stage between NREQ
//           requesters; each request evaluates a piecewise-linear sigmoid in Q8.24.
// Latency : o_gnt pulse in cycle T, o_valid first high in T+3; at least 5 cycles between captures.
// Backpr. : the result is held in OUT until i_ready; requests that arrive meanwhile wait.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   i_req/i_data  per-requester request and operand x (requester k at [k*WIDTH +: WIDTH])
//   o_gnt         one-hot single-cycle pulse: operand of that requester was captured
//   o_seg_x       registered |x| to the external segmentation block
//   i_seg_ctrl    segment code back from segmentation (0..4, 7 = saturated)
//   i_seg_mid     segment centre from segmentation
//   i_cfg_*       coefficient table write port (addr = segment code)
//   o_valid/i_ready/o_id/o_data  result handshake, requester id and sigmoid value
//   o_busy        high whenever the FSM is not idle
module act_scheduler #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_data,
  output logic [NREQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]      o_seg_x,
  input  logic [2:0]            i_seg_ctrl,
  input  logic [WIDTH-1:0]      i_seg_mid,
  input  logic                  i_cfg_we,
  input  logic [2:0]            i_cfg_addr,
  input  logic [WIDTH-1:0]      i_cfg_slope,
  input  logic [WIDTH-1:0]      i_cfg_off,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [IDW-1:0]        o_id,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(32'h0100_0000);

  // Reset coefficients: sigmoid and its derivative at the segment centres
  // 0.5, 1.5, 2.5, 3.5, 4.5; entry 7 is the saturated tail (1.0, flat).
  localparam logic [31:0] RST_OFF [8] = '{
    32'h009F_5979, 32'h00D1_4C88, 32'h00EC_9492, 32'h00F8_7EFE,
    32'h00FD_2FF3, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000};
  localparam logic [31:0] RST_SLOPE [8] = '{
    32'h003C_293B, 32'h0026_2E6E, 32'h0011_F256, 32'h0007_48B2,
    32'h0002_C81D, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

  typedef enum logic [2:0] {S_IDLE, S_SEG, S_MUL, S_ADD, S_OUT} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0]           ptr, win, cand, id_r;
  logic                     any_req;
  logic [WIDTH-1:0]         sel_x;
  logic                     sign_r;
  logic [2:0]               ctrl_r;
  logic signed [WIDTH-1:0]  slope_r, off_r, diff_r, term_r;
  logic signed [WIDTH-1:0]  ypos, ymir, yclamp;
  logic signed [PW-1:0]     prod;
  logic signed [WIDTH-1:0]  tbl_slope [8];
  logic signed [WIDTH-1:0]  tbl_off   [8];
  logic                     unused_prod_bits;

  // Round-robin: first requester found searching upward from ptr+1.
  always_comb begin
    win     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!any_req && i_req[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  assign sel_x = i_data[win*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_SEG;
      S_SEG:   state_nxt = S_MUL;
      S_MUL:   state_nxt = S_ADD;
      S_ADD:   state_nxt = S_OUT;
      S_OUT:   if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE);

  // Full-width signed product; Q8.24 * Q8.24 keeps bits [WIDTH+23:24].
  assign prod = PW'(slope_r) * PW'(diff_r);
  assign unused_prod_bits = ^{prod[PW-1:WIDTH+24], prod[23:0]};

  // Saturated segment ignores the product term; negative x mirrors around 0.5.
  always_comb begin
    ypos = (ctrl_r == 3'd7) ? off_r : off_r + term_r;
    ymir = sign_r ? ONE - ypos : ypos;
    if (ymir[WIDTH-1])  yclamp = '0;
    else if (ymir > ONE) yclamp = ONE;
    else                 yclamp = ymir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= IDW'(NREQ - 1);
      o_gnt   <= '0;
      o_seg_x <= '0;
      sign_r  <= 1'b0;
      id_r    <= '0;
      ctrl_r  <= '0;
      slope_r <= '0;
      off_r   <= '0;
      diff_r  <= '0;
      term_r  <= '0;
      o_valid <= 1'b0;
      o_id    <= '0;
      o_data  <= '0;
    end else begin
      o_gnt <= '0;
      case (state)
        S_IDLE: if (any_req) begin
          ptr     <= win;
          id_r    <= win;
          o_gnt   <= NREQ'(1) << win;
          sign_r  <= sel_x[WIDTH-1];
          // 0x8000_0000 negates to itself; segmentation reports it saturated.
          o_seg_x <= sel_x[WIDTH-1] ? (~sel_x + WIDTH'(1)) : sel_x;
        end
        S_SEG: begin
          // Table read sees the pre-write value when a write lands this cycle.
          ctrl_r  <= i_seg_ctrl;
          slope_r <= tbl_slope[i_seg_ctrl];
          off_r   <= tbl_off[i_seg_ctrl];
          diff_r  <= o_seg_x - i_seg_mid;
        end
        S_MUL: term_r <= prod[WIDTH+23:24];
        S_ADD: begin
          o_data  <= yclamp;
          o_id    <= id_r;
          o_valid <= 1'b1;
        end
        S_OUT: if (i_ready) o_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 8; c++) begin
        tbl_slope[c] <= WIDTH'(RST_SLOPE[c]);
        tbl_off[c]   <= WIDTH'(RST_OFF[c]);
      end
    end else if (i_cfg_we) begin
      tbl_slope[i_cfg_addr] <= i_cfg_slope;
      tbl_off[i_cfg_addr]   <= i_cfg_off;
    end
  end

endmodule

// File: tb/tb_act_scheduler.sv
// Purpose : randomized and directed check of act_scheduler against a sigmoid reference model.
// Latency : expects o_gnt in T, o_valid in T+3, release one cycle after i_ready.
// Backpr. : stalls i_ready for random spans and checks the result stays frozen.
module tb_act_scheduler;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   o_gnt;
  logic [W-1:0]   o_seg_x;
  logic [2:0]     i_seg_ctrl;
  logic [W-1:0]   i_seg_mid;
  logic           i_cfg_we;
  logic [2:0]     i_cfg_addr;
  logic [W-1:0]   i_cfg_slope, i_cfg_off;
  logic           o_valid, i_ready;
  logic [1:0]     o_id;
  logic [W-1:0]   o_data;
  logic           o_busy;

  int n_vec = 0;
  int n_err = 0;
  int seg_ovr = -1;
  int m_ptr;
  int m_slope [8];
  int m_off   [8];
  logic [W-1:0] last_data;
  logic [1:0]   last_id;

  always #5 clk = ~clk;

  act_scheduler #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_data(i_data), .o_gnt(o_gnt),
    .o_seg_x(o_seg_x), .i_seg_ctrl(i_seg_ctrl), .i_seg_mid(i_seg_mid),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_slope(i_cfg_slope),
    .i_cfg_off(i_cfg_off), .o_valid(o_valid), .i_ready(i_ready), .o_id(o_id),
    .o_data(o_data), .o_busy(o_busy)
  );

  // External segmentation: unit-wide segments [k, k+1) centred at k+0.5, saturated from 5.0.
  always_comb begin
    i_seg_ctrl = 3'd7;
    i_seg_mid  = '0;
    if (o_seg_x < 32'h0500_0000) begin
      i_seg_ctrl = o_seg_x[26:24];
      i_seg_mid  = {o_seg_x[31:24], 24'h80_0000};
    end
    if (seg_ovr >= 0) i_seg_ctrl = seg_ovr[2:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = N - 1;
    m_off   = '{32'h009F_5979, 32'h00D1_4C88, 32'h00EC_9492, 32'h00F8_7EFE,
                32'h00FD_2FF3, 0, 0, 32'h0100_0000};
    m_slope = '{32'h003C_293B, 32'h0026_2E6E, 32'h0011_F256, 32'h0007_48B2,
                32'h0002_C81D, 0, 0, 0};
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // y = off + slope*(|x| - mid), mirrored as 1 - y for negative x, clamped to [0, 1.0].
  function automatic logic [31:0] model_y(input logic [31:0] x);
    logic [31:0] ax;
    int code, mid, diff, term, ypos, y;
    longint p;
    ax = x[31] ? (32'd0 - x) : x;
    if (ax < 32'h0500_0000) begin
      code = int'(ax >> 24);
      mid  = int'(ax & 32'hFF00_0000) + 32'h0080_0000;
    end else begin
      code = 7;
      mid  = 0;
    end
    if (seg_ovr >= 0) code = seg_ovr;
    diff = int'(ax) - mid;
    p    = longint'(m_slope[code]) * longint'(diff);
    term = int'(p >>> 24);
    ypos = (code == 7) ? m_off[code] : m_off[code] + term;
    y    = x[31] ? (32'h0100_0000 - ypos) : ypos;
    if (y < 0) y = 0;
    else if (y > 32'h0100_0000) y = 32'h0100_0000;
    return 32'(y);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] s, input logic [31:0] o);
    @(posedge clk); #1;
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_slope = s; i_cfg_off = o;
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
    m_slope[a] = int'(s);
    m_off[a]   = int'(o);
  endtask

  // Waits for the next grant and follows that transaction to acceptance.
  task automatic serve(input bit drop, input int stall);
    int w, cyc;
    logic [31:0] x, ey;
    w = model_pick(i_req);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (o_gnt == '0 && cyc < 40);
    check("gnt", 32'(o_gnt), (w < 0) ? 32'd0 : 32'(1 << w));
    if (o_gnt == '0 || w < 0) return;
    m_ptr = w;
    x  = i_data[w*W +: W];
    ey = model_y(x);
    check("seg_x", o_seg_x, x[31] ? (32'd0 - x) : x);
    check("busy", 32'(o_busy), 32'd1);
    i_ready = (stall == 0);
    @(posedge clk); #1;
    if (drop) i_req[w] = 1'b0;
    @(negedge clk);
    check("gnt_pulse", 32'(o_gnt), 32'd0);
    @(negedge clk);
    check("early_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    check("valid", 32'(o_valid), 32'd1);
    check("data", o_data, ey);
    check("id", 32'(o_id), 32'(w));
    last_data = o_data;
    last_id   = o_id;
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk); #1;
      if (s == stall) i_ready = 1'b1;
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data", o_data, ey);
      check("hold_gnt", 32'(o_gnt), 32'd0);
    end
    @(negedge clk);
    check("accept", 32'(o_valid), 32'd0);
  endtask

  task automatic one(input int k, input logic [31:0] x, input int stall);
    i_data[k*W +: W] = x;
    i_req = N'(1) << k;
    serve(1'b1, stall);
  endtask

  initial begin
    int cyc;
    bit quiet;
    i_req = '0; i_data = '0; i_cfg_we = 1'b0; i_cfg_addr = '0;
    i_cfg_slope = '0; i_cfg_off = '0; i_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_id", 32'(o_id), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_seg_x", o_seg_x, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    #1 rst = 1'b0;
    model_reset();

    // Default table, segment 0.
    one(0, 32'h0040_0000, 0);

    // Directed coefficient cases.
    cfg_write(3'd1, 32'h0040_0000, 32'h00C0_0000);
    one(0, 32'h01C0_0000, 0);
    check("t1_data", last_data, 32'h00D0_0000);
    check("t1_id", 32'(last_id), 32'd0);
    one(2, 32'hFE40_0000, 0);
    check("t2_data", last_data, 32'h0030_0000);
    check("t2_id", 32'(last_id), 32'd2);
    one(1, 32'h0800_0000, 0);
    check("sat_pos", last_data, 32'h0100_0000);
    one(3, 32'hF800_0000, 0);
    check("sat_neg", last_data, 32'h0000_0000);
    one(0, 32'h8000_0000, 1);
    check("most_neg", last_data, 32'h0000_0000);

    // Out-of-range segment codes read the untouched entries 5/6.
    seg_ovr = 5;
    one(1, 32'h0100_0000, 0);
    check("ctrl5_pos", last_data, 32'h0000_0000);
    seg_ovr = 6;
    one(2, 32'hFF00_0000, 0);
    check("ctrl6_neg", last_data, 32'h0100_0000);
    seg_ovr = -1;

    // Long stall with another requester waiting.
    i_data[1*W +: W] = 32'h0123_4567;
    i_data[3*W +: W] = 32'hFD80_0000;
    i_req = 4'b1010;
    serve(1'b1, 10);
    serve(1'b1, 0);

    // Reset while the multiply is in flight.
    i_data[2*W +: W] = 32'h0200_0000;
    i_req = 4'b0100;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (o_gnt == '0 && cyc < 40);
    check("rst_mid_gnt", 32'(o_gnt), 32'b0100);
    @(posedge clk); #1;
    rst = 1'b1; i_req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    quiet = 1'b1;
    repeat (6) begin @(negedge clk); if (o_valid) quiet = 1'b0; end
    check("rst_mid_quiet", 32'(quiet), 32'd1);
    i_data[0*W +: W] = 32'h0800_0000;
    i_req = 4'b0101;
    serve(1'b1, 0);
    check("rst_mid_next", 32'(last_id), 32'd0);
    i_req = '0;

    // All four held from reset: strict rotation.
    do_reset();
    for (int k = 0; k < N; k++) i_data[k*W +: W] = 32'($urandom_range(0, 32'h0600_0000));
    i_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      serve(1'b0, g % 2);
      check("rr_order", 32'(last_id), 32'(g % N));
    end
    i_req = '0;

    // Random bursts: held requests drain in round-robin order.
    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write(3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000,
                  32'($urandom_range(0, 32'h0200_0000)) - 32'h0080_0000);
      seg_ovr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 6)) : -1;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) i_data[k*W +: W] = $urandom;
        else i_data[k*W +: W] = 32'($urandom_range(0, 32'h0C00_0000)) - 32'h0600_0000;
      end
      @(posedge clk); #1;
      i_req = N'($urandom_range(1, 15));
      while (i_req != '0) serve(1'b1, int'($urandom_range(0, 3)));
    end
    seg_ovr = -1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
